// File: rtl/cp15_pkg.sv
// cp15_pkg: shared constants for the CP15 system-control coprocessor.
// Holds the CRn register indices, the ID and cache-type values, the control
// register reset value and writable mask, the c7/c8 CRm opcodes and the bit
// positions inside the maintenance pulse vector.
package cp15_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CRN_W  = 4;
    localparam int unsigned CRM_W  = 4;
    localparam int unsigned OP2_W  = 3;
    localparam int unsigned NPULSE = 6;

    // CRn register indices
    localparam logic [CRN_W-1:0] CR_ID    = 4'd0;
    localparam logic [CRN_W-1:0] CR_CTRL  = 4'd1;
    localparam logic [CRN_W-1:0] CR_TTB   = 4'd2;
    localparam logic [CRN_W-1:0] CR_DOM   = 4'd3;
    localparam logic [CRN_W-1:0] CR_FSR   = 4'd5;
    localparam logic [CRN_W-1:0] CR_FAR   = 4'd6;
    localparam logic [CRN_W-1:0] CR_CACHE = 4'd7;
    localparam logic [CRN_W-1:0] CR_TLB   = 4'd8;
    localparam logic [CRN_W-1:0] CR_PID   = 4'd13;

    // Read-only identification values
    localparam logic [DATA_W-1:0] CP15_ID         = 32'h4106_9260;
    localparam logic [DATA_W-1:0] CP15_CACHE_TYPE = 32'h0000_0000;

    // Control register: writable bits 0-2, 7-9, 12-14; bits 3-6 always 1
    localparam logic [DATA_W-1:0] CTRL_RESET = 32'h0000_0078;
    localparam logic [DATA_W-1:0] CTRL_WMASK = 32'h0000_7387;
    localparam logic [DATA_W-1:0] CTRL_ONES  = 32'h0000_0078;

    localparam logic [DATA_W-1:0] TTB_MASK = 32'hFFFF_C000;
    localparam logic [DATA_W-1:0] FSR_MASK = 32'h0000_00FF;
    localparam logic [DATA_W-1:0] PID_MASK = 32'hFE00_0000;

    // c7 cache maintenance CRm opcodes
    localparam logic [CRM_W-1:0] CRM_INV_I       = 4'd5;
    localparam logic [CRM_W-1:0] CRM_INV_D       = 4'd6;
    localparam logic [CRM_W-1:0] CRM_INV_ID      = 4'd7;
    localparam logic [CRM_W-1:0] CRM_CLEAN_D     = 4'd10;
    localparam logic [CRM_W-1:0] CRM_CLEAN_INV_D = 4'd14;

    // c8 TLB maintenance CRm opcodes
    localparam logic [CRM_W-1:0] CRM_TLB_I  = 4'd5;
    localparam logic [CRM_W-1:0] CRM_TLB_D  = 4'd6;
    localparam logic [CRM_W-1:0] CRM_TLB_ID = 4'd7;

    // Bit positions in the maintenance pulse vector
    localparam int unsigned P_INVI   = 0;
    localparam int unsigned P_INVD   = 1;
    localparam int unsigned P_CLEANI = 2;
    localparam int unsigned P_CLEAND = 3;
    localparam int unsigned P_TLBI   = 4;
    localparam int unsigned P_TLBD   = 5;

endpackage

// File: rtl/cp15_maint_decode.sv
// cp15_maint_decode: combinational decode of MCR c7/c8 writes into the
// next-cycle maintenance pulse vector (bit positions from cp15_pkg).
// Ports:
//   wr_en       - qualified CPU write this cycle
//   crn         - CRn register select
//   crm         - CRm field
//   pulse_nxt_c - pulses to be registered by the parent
module cp15_maint_decode
    import cp15_pkg::*;
(
    input  logic              wr_en,
    input  logic [CRN_W-1:0]  crn,
    input  logic [CRM_W-1:0]  crm,
    output logic [NPULSE-1:0] pulse_nxt_c
);

    // CleanI is never produced; the slot stays 0
    always_comb begin
        pulse_nxt_c = '0;
        if (wr_en && crn == CR_CACHE) begin
            case (crm)
                CRM_INV_I:       pulse_nxt_c[P_INVI] = 1'b1;
                CRM_INV_D:       pulse_nxt_c[P_INVD] = 1'b1;
                CRM_INV_ID: begin
                    pulse_nxt_c[P_INVI] = 1'b1;
                    pulse_nxt_c[P_INVD] = 1'b1;
                end
                CRM_CLEAN_D:     pulse_nxt_c[P_CLEAND] = 1'b1;
                CRM_CLEAN_INV_D: begin
                    pulse_nxt_c[P_CLEAND] = 1'b1;
                    pulse_nxt_c[P_INVD]   = 1'b1;
                end
                default: ;
            endcase
        end else if (wr_en && crn == CR_TLB) begin
            case (crm)
                CRM_TLB_I:  pulse_nxt_c[P_TLBI] = 1'b1;
                CRM_TLB_D:  pulse_nxt_c[P_TLBD] = 1'b1;
                CRM_TLB_ID: begin
                    pulse_nxt_c[P_TLBI] = 1'b1;
                    pulse_nxt_c[P_TLBD] = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cp15_sysctrl.sv
// cp15_sysctrl: CP15 system-control coprocessor for the LEG core.
// Holds ID, control, TTB, domain, FSR, FAR and (optionally) FCSE PID, and
// turns MCR c7/c8 writes into one-cycle registered maintenance pulses.
// Build option: define CP15_FCSE_EN to implement the c13 FCSE PID register.
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   CPUEn, CPUWriteEn   - coprocessor access valid / MCR strobe
//   MMUEn, MMUWriteEn   - MMU access valid / fault-address write strobe
//   addr, opcode_2, CRm - CRn, op2 and CRm fields
//   CPUWriteData        - MCR data; MMUWriteData - fault virtual address
//   StallCP             - pipeline hold while any maintenance pulse is high
//   INVI/INVD/CleanI/CleanD/TLBFlushI/TLBFlushD - maintenance pulses
//   rd                  - MRC read data (combinational)
//   control, tbase      - c1 control and c2 translation-table base
module cp15_sysctrl
    import cp15_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              CPUWriteEn,
    input  logic              CPUEn,
    input  logic              MMUWriteEn,
    input  logic              MMUEn,
    input  logic [CRN_W-1:0]  addr,
    input  logic [DATA_W-1:0] CPUWriteData,
    input  logic [DATA_W-1:0] MMUWriteData,
    input  logic [OP2_W-1:0]  opcode_2,
    input  logic [CRM_W-1:0]  CRm,
    output logic              StallCP,
    output logic              INVI,
    output logic              INVD,
    output logic              CleanI,
    output logic              CleanD,
    output logic              TLBFlushD,
    output logic              TLBFlushI,
    output logic [DATA_W-1:0] rd,
    output logic [DATA_W-1:0] control,
    output logic [DATA_W-1:0] tbase
);

    logic              cpu_wr;
    logic              mmu_wr;
    logic [DATA_W-1:0] ctrl_q;
    logic [DATA_W-1:0] ttb_q;
    logic [DATA_W-1:0] dom_q;
    logic [DATA_W-1:0] fsr_q;
    logic [DATA_W-1:0] far_q;
    logic [NPULSE-1:0] pulse_q;
    logic [NPULSE-1:0] pulse_nxt;
    logic              stall_q;
`ifdef CP15_FCSE_EN
    logic [DATA_W-1:0] pid_q;
`endif

    assign cpu_wr = CPUEn & CPUWriteEn;
    assign mmu_wr = MMUEn & MMUWriteEn;

    cp15_maint_decode u_decode (
        .wr_en       (cpu_wr),
        .crn         (addr),
        .crm         (CRm),
        .pulse_nxt_c (pulse_nxt)
    );

    // Register file and pulse stage; stored values are pre-masked so reads are direct
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q  <= CTRL_RESET;
            ttb_q   <= '0;
            dom_q   <= '0;
            fsr_q   <= '0;
            far_q   <= '0;
            pulse_q <= '0;
            stall_q <= 1'b0;
`ifdef CP15_FCSE_EN
            pid_q   <= '0;
`endif
        end else begin
            pulse_q <= pulse_nxt;
            stall_q <= |pulse_nxt;
            if (cpu_wr) begin
                case (addr)
                    CR_CTRL: ctrl_q <= (CPUWriteData & CTRL_WMASK) | CTRL_ONES;
                    CR_TTB:  ttb_q  <= CPUWriteData & TTB_MASK;
                    CR_DOM:  dom_q  <= CPUWriteData;
                    CR_FSR:  fsr_q  <= CPUWriteData & FSR_MASK;
                    CR_FAR:  far_q  <= CPUWriteData;
`ifdef CP15_FCSE_EN
                    CR_PID:  pid_q  <= CPUWriteData & PID_MASK;
`endif
                    default: ;
                endcase
            end
            // MMU fault address overrides a same-cycle CPU write
            if (mmu_wr) begin
                far_q <= MMUWriteData;
            end
        end
    end

    // MRC read mux
    always_comb begin
        rd = '0;
        if (CPUEn) begin
            case (addr)
                CR_ID: begin
                    if (opcode_2 == 3'd0) begin
                        rd = CP15_ID;
                    end else if (opcode_2 == 3'd1) begin
                        rd = CP15_CACHE_TYPE;
                    end
                end
                CR_CTRL: rd = ctrl_q;
                CR_TTB:  rd = ttb_q;
                CR_DOM:  rd = dom_q;
                CR_FSR:  rd = fsr_q;
                CR_FAR:  rd = far_q;
`ifdef CP15_FCSE_EN
                CR_PID:  rd = pid_q;
`endif
                default: rd = '0;
            endcase
        end
    end

    assign control   = ctrl_q;
    assign tbase     = ttb_q;
    assign INVI      = pulse_q[P_INVI];
    assign INVD      = pulse_q[P_INVD];
    assign CleanI    = pulse_q[P_CLEANI];
    assign CleanD    = pulse_q[P_CLEAND];
    assign TLBFlushI = pulse_q[P_TLBI];
    assign TLBFlushD = pulse_q[P_TLBD];
    assign StallCP   = stall_q;

endmodule

// File: tb/tb_cp15_sysctrl.sv
// tb_cp15_sysctrl: directed self-checking bench for cp15_sysctrl.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// Honours CP15_FCSE_EN for the c13 expectations.
module tb_cp15_sysctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        CPUWriteEn, CPUEn, MMUWriteEn, MMUEn;
    logic [3:0]  addr;
    logic [31:0] CPUWriteData, MMUWriteData;
    logic [2:0]  opcode_2;
    logic [3:0]  CRm;
    logic        StallCP, INVI, INVD, CleanI, CleanD, TLBFlushD, TLBFlushI;
    logic [31:0] rd, control, tbase;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse vector: {TLBFlushI, TLBFlushD, CleanD, CleanI, INVD, INVI, StallCP}
    wire [6:0] pv = {TLBFlushI, TLBFlushD, CleanD, CleanI, INVD, INVI, StallCP};

    always #5 clk = ~clk;

    cp15_sysctrl dut (
        .clk          (clk),
        .reset        (reset),
        .CPUWriteEn   (CPUWriteEn),
        .CPUEn        (CPUEn),
        .MMUWriteEn   (MMUWriteEn),
        .MMUEn        (MMUEn),
        .addr         (addr),
        .CPUWriteData (CPUWriteData),
        .MMUWriteData (MMUWriteData),
        .opcode_2     (opcode_2),
        .CRm          (CRm),
        .StallCP      (StallCP),
        .INVI         (INVI),
        .INVD         (INVD),
        .CleanI       (CleanI),
        .CleanD       (CleanD),
        .TLBFlushD    (TLBFlushD),
        .TLBFlushI    (TLBFlushI),
        .rd           (rd),
        .control      (control),
        .tbase        (tbase)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mcr(input logic [3:0] a, input logic [3:0] m, input logic [31:0] d);
        CPUEn = 1'b1; CPUWriteEn = 1'b1; addr = a; CRm = m; CPUWriteData = d;
        tick();
        CPUEn = 1'b0; CPUWriteEn = 1'b0;
    endtask

    task automatic mrc(input logic [3:0] a, input logic [2:0] op2,
                       input string tag, input logic [31:0] exp);
        CPUEn = 1'b1; CPUWriteEn = 1'b0; addr = a; opcode_2 = op2;
        #1;
        check(tag, rd, exp);
        CPUEn = 1'b0; opcode_2 = 3'd0;
        #1;
    endtask

    // One maintenance MCR: pulses in the cycle after the edge, clear the next
    task automatic maint(input logic [3:0] a, input logic [3:0] m,
                         input logic [6:0] exp, input string tag);
        mcr(a, m, 32'hFFFF_FFFF);
        check({tag, " pulse"}, 32'(pv), 32'(exp));
        tick();
        check({tag, " clear"}, 32'(pv), 32'h0);
    endtask

    initial begin
        reset = 1'b0; CPUWriteEn = 1'b0; CPUEn = 1'b0; MMUWriteEn = 1'b0; MMUEn = 1'b0;
        addr = 4'd0; CPUWriteData = '0; MMUWriteData = '0; opcode_2 = 3'd0; CRm = 4'd0;
        tick(); tick();
        reset = 1'b1;
        tick();

        // Reset state
        check("rst control", control, 32'h0000_0078);
        check("rst tbase", tbase, 32'h0);
        check("rst pulses", 32'(pv), 32'h0);
        addr = 4'd1; #1;
        check("rd idle", rd, 32'h0);
        mrc(4'd1, 3'd0, "rst rd c1", 32'h0000_0078);
        mrc(4'd3, 3'd0, "rst c3", 32'h0);
        mrc(4'd6, 3'd0, "rst c6", 32'h0);

        // Control register masking
        mcr(4'd1, 4'd0, 32'hFFFF_FFFF);
        check("ctrl all", control, 32'h0000_73FF);
        check("ctrl bit13", 32'(control[13]), 32'h1);
        mrc(4'd1, 3'd0, "rd c1 all", 32'h0000_73FF);
        mcr(4'd1, 4'd0, 32'h0000_0000);
        check("ctrl zero", control, 32'h0000_0078);

        // TTB, ID, cache type, write to c0 ignored
        mcr(4'd2, 4'd0, 32'h1234_5678);
        check("tbase", tbase, 32'h1234_4000);
        mrc(4'd2, 3'd0, "rd c2", 32'h1234_4000);
        mrc(4'd0, 3'd0, "rd id", 32'h4106_9260);
        mrc(4'd0, 3'd1, "rd ctype", 32'h0);
        mcr(4'd0, 4'd0, 32'hFFFF_FFFF);
        mrc(4'd0, 3'd0, "rd id after wr", 32'h4106_9260);

        // Domain and FSR
        mcr(4'd3, 4'd0, 32'hDEAD_BEEF);
        mrc(4'd3, 3'd0, "rd c3", 32'hDEAD_BEEF);
        mcr(4'd5, 4'd0, 32'h1234_56A5);
        mrc(4'd5, 3'd0, "rd c5", 32'h0000_00A5);

        // Undefined CRn
        mcr(4'd4, 4'd0, 32'hFFFF_FFFF);
        mrc(4'd4, 3'd0, "rd c4", 32'h0);

        // Maintenance decode
        maint(4'd7, 4'd14, 7'h15, "c7 cleaninvd");
        maint(4'd8, 4'd7,  7'h61, "c8 tlb both");
        maint(4'd7, 4'd5,  7'h03, "c7 invi");
        maint(4'd7, 4'd6,  7'h05, "c7 invd");
        maint(4'd7, 4'd7,  7'h07, "c7 inv both");
        maint(4'd7, 4'd10, 7'h11, "c7 cleand");
        maint(4'd7, 4'd3,  7'h00, "c7 other");
        maint(4'd8, 4'd5,  7'h41, "c8 tlbi");
        maint(4'd8, 4'd6,  7'h21, "c8 tlbd");
        maint(4'd3, 4'd7,  7'h00, "c3 crm7");
        mrc(4'd7, 3'd0, "rd c7", 32'h0);
        mrc(4'd8, 3'd0, "rd c8", 32'h0);
        mrc(4'd3, 3'd0, "c3 kept", 32'hFFFF_FFFF);

        // Back-to-back maintenance writes
        CPUEn = 1'b1; CPUWriteEn = 1'b1; addr = 4'd7; CRm = 4'd5;
        tick();
        check("b2b 1", 32'(pv), 32'h03);
        tick();
        check("b2b 2", 32'(pv), 32'h03);
        addr = 4'd8; CRm = 4'd6;
        tick();
        check("b2b 3", 32'(pv), 32'h21);
        CPUEn = 1'b0; CPUWriteEn = 1'b0;
        tick();
        check("b2b end", 32'(pv), 32'h0);

        // FAR: CPU write, MMU wins collision, MMU strobe needs MMUEn
        mcr(4'd6, 4'd0, 32'h1234_0000);
        mrc(4'd6, 3'd0, "far cpu", 32'h1234_0000);
        CPUEn = 1'b1; CPUWriteEn = 1'b1; addr = 4'd6; CPUWriteData = 32'hAAAA_0000;
        MMUEn = 1'b1; MMUWriteEn = 1'b1; MMUWriteData = 32'h0000_BEEF;
        tick();
        CPUEn = 1'b0; CPUWriteEn = 1'b0; MMUEn = 1'b0; MMUWriteEn = 1'b0;
        mrc(4'd6, 3'd0, "far collision", 32'h0000_BEEF);
        MMUEn = 1'b0; MMUWriteEn = 1'b1; MMUWriteData = 32'h5555_5555;
        tick();
        MMUWriteEn = 1'b0;
        mrc(4'd6, 3'd0, "far no mmuen", 32'h0000_BEEF);
        MMUEn = 1'b1; MMUWriteEn = 1'b1; MMUWriteData = 32'h0BAD_F00D;
        tick();
        MMUEn = 1'b0; MMUWriteEn = 1'b0;
        mrc(4'd6, 3'd0, "far mmu", 32'h0BAD_F00D);

        // FCSE PID
        mcr(4'd13, 4'd0, 32'hFFFF_FFFF);
`ifdef CP15_FCSE_EN
        mrc(4'd13, 3'd0, "pid masked", 32'hFE00_0000);
`else
        mrc(4'd13, 3'd0, "pid absent", 32'h0);
`endif
        mcr(4'd13, 4'd0, 32'hFE00_0000);
`ifdef CP15_FCSE_EN
        mrc(4'd13, 3'd0, "pid rd", 32'hFE00_0000);
`else
        mrc(4'd13, 3'd0, "pid rd", 32'h0);
`endif

        // Reset on the same edge as a maintenance MCR suppresses the pulse
        mcr(4'd1, 4'd0, 32'hFFFF_FFFF);
        CPUEn = 1'b1; CPUWriteEn = 1'b1; addr = 4'd7; CRm = 4'd5;
        reset = 1'b0;
        tick();
        check("rst mid pulse", 32'(pv), 32'h0);
        CPUEn = 1'b0; CPUWriteEn = 1'b0;
        reset = 1'b1;
        tick();
        check("rst mid after", 32'(pv), 32'h0);
        check("rst mid ctrl", control, 32'h0000_0078);
        mrc(4'd6, 3'd0, "rst mid far", 32'h0);
        mrc(4'd2, 3'd0, "rst mid c2", 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
